// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH independent PWM outputs sharing one prescaled
// period counter. Each channel has a pending (software-visible) duty register
// and an active duty register. Pending values move into the active set only
// at the period boundary, so a period is never cut short or stretched by a
// mid-period write.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg_we         one-cycle duty write strobe
//   cfg_ch         channel index for the write (out-of-range writes dropped)
//   cfg_duty       duty value for the write
//   out_en         per-channel output enable (level, not shadowed)
//   pwm_en         per-channel PWM mode; 0 = static high when enabled
//   prescale       tick divider; one counter tick every prescale+1 clk
//   pwm_out        registered channel outputs
//   period_start   one-cycle pulse in the first cycle the counter reads 0
module pwm_multichannel #(
  parameter int unsigned NUM_CH  = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_duty,
  input  logic [NUM_CH-1:0]         out_en,
  input  logic [NUM_CH-1:0]         pwm_en,
  input  logic [PRESC_W-1:0]        prescale,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      period_start
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  // Last counter value before the wrap; the period is 2**CNT_W-1 ticks.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CNT_W) - 2);

  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   pending [NUM_CH];
  logic [CNT_W-1:0]   active  [NUM_CH];

  logic tick_c;
  logic wrap_c;
  logic wr_ok_c;

  // Tick/wrap decode. ">=" rather than "==" means lowering prescale below the
  // current presc_cnt produces a tick on the next edge instead of a long
  // count-up through the whole prescaler range.
  always_comb begin
    tick_c  = 1'b0;
    wrap_c  = 1'b0;
    wr_ok_c = 1'b0;
    tick_c  = (presc_cnt >= prescale);
    wrap_c  = tick_c && (cnt == CNT_LAST);
    wr_ok_c = cfg_we && (32'(cfg_ch) < NUM_CH);
  end

  // Prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick_c) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // Period counter: 0 .. CNT_LAST, advancing on tick only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap_c) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending duty registers, written by the configuration port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) pending[i] <= '0;
    end else if (wr_ok_c) begin
      pending[cfg_ch] <= cfg_duty;
    end
  end

  // Active duty registers. A write landing on the wrap cycle is forwarded so
  // it is not lost behind the pending register for a whole period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) active[i] <= '0;
    end else if (wrap_c) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          active[i] <= cfg_duty;
        end else begin
          active[i] <= pending[i];
        end
      end
    end
  end

  // Registered outputs; enables act directly, duty compares against cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!out_en[i]) begin
          pwm_out[i] <= 1'b0;
        end else if (!pwm_en[i]) begin
          pwm_out[i] <= 1'b1;
        end else begin
          pwm_out[i] <= (cnt < active[i]);
        end
      end
      period_start <= wrap_c;
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Testbench for pwm_multichannel: a 16-channel instance exercising duty,
// enables, double buffering, wrap forwarding and prescaler behaviour, and a
// 12-channel instance checking that out-of-range channel writes are dropped.
// Expected values are queued when stimulus is applied and compared in order
// as measurements complete.
module tb_pwm_multichannel;

  logic        clk;
  logic        rst_n;

  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [7:0]  cfg_duty;
  logic [15:0] out_en;
  logic [15:0] pwm_en;
  logic [7:0]  prescale;
  logic [15:0] pwm_out;
  logic        period_start;

  logic        cfg_we12;
  logic [3:0]  cfg_ch12;
  logic [7:0]  cfg_duty12;
  logic [11:0] out_en12;
  logic [11:0] pwm_en12;
  logic [7:0]  prescale12;
  logic [11:0] pwm_out12;
  logic        ps12;

  int total;
  int bad;

  string tag_q[$];
  int    val_q[$];

  int hi16[16];
  int hi12[12];
  int ps16_n, ps16_last, ps12_n, ps12_last;
  int n_cyc, n_hi3;

  pwm_multichannel #(.NUM_CH(16), .CNT_W(8), .PRESC_W(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_duty     (cfg_duty),
    .out_en       (out_en),
    .pwm_en       (pwm_en),
    .prescale     (prescale),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  pwm_multichannel #(.NUM_CH(12), .CNT_W(8), .PRESC_W(8)) u_dut12 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we12),
    .cfg_ch       (cfg_ch12),
    .cfg_duty     (cfg_duty12),
    .out_en       (out_en12),
    .pwm_en       (pwm_en12),
    .prescale     (prescale12),
    .pwm_out      (pwm_out12),
    .period_start (ps12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_exp(input string tag, input int val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic observe(input int obs);
    string t;
    int    e;
    total++;
    if (val_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until period_start (16-ch instance) is seen, bounded by a budget.
  task automatic run_to_ps(output int n, output int h3);
    n  = 0;
    h3 = 0;
    do begin
      step();
      n++;
      h3 += int'(pwm_out[3]);
    end while (!period_start && n < 3000);
  endtask

  task automatic write16(input int ch, input int duty);
    cfg_we   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_duty = 8'(duty);
    step();
    cfg_we   = 1'b0;
  endtask

  // One 255-cycle window starting just after a period_start sample.
  // Optional single write per instance, issued so it is sampled while the
  // counter reads the given index (-1 = no write).
  task automatic window(input int w_at, input int w_ch, input int w_d,
                        input int w12_at, input int w12_ch, input int w12_d);
    for (int i = 0; i < 16; i++) hi16[i] = 0;
    for (int i = 0; i < 12; i++) hi12[i] = 0;
    ps16_n = 0; ps16_last = 0; ps12_n = 0; ps12_last = 0;
    for (int s = 0; s < 255; s++) begin
      if (s == w_at) begin
        cfg_we = 1'b1; cfg_ch = 4'(w_ch); cfg_duty = 8'(w_d);
      end
      if (s == w12_at) begin
        cfg_we12 = 1'b1; cfg_ch12 = 4'(w12_ch); cfg_duty12 = 8'(w12_d);
      end
      step();
      cfg_we   = 1'b0;
      cfg_we12 = 1'b0;
      for (int i = 0; i < 16; i++) hi16[i] += int'(pwm_out[i]);
      for (int i = 0; i < 12; i++) hi12[i] += int'(pwm_out12[i]);
      ps16_n   += int'(period_start);
      ps16_last = int'(period_start);
      ps12_n   += int'(ps12);
      ps12_last = int'(ps12);
    end
  endtask

  task automatic exp16(input int c0, input int c1, input int c2, input int c3);
    push_exp("ch0_high", c0);
    push_exp("ch1_high", c1);
    push_exp("ch2_high", c2);
    push_exp("ch3_high", c3);
    push_exp("ch4to15_high", 0);
    push_exp("ps_count", 1);
    push_exp("ps_at_end", 1);
  endtask

  task automatic obs16();
    int rest;
    rest = 0;
    for (int i = 4; i < 16; i++) rest += hi16[i];
    observe(hi16[0]);
    observe(hi16[1]);
    observe(hi16[2]);
    observe(hi16[3]);
    observe(rest);
    observe(ps16_n);
    observe(ps16_last);
  endtask

  task automatic exp12(input int c11, input int c5);
    push_exp("d12_ch11_high", c11);
    push_exp("d12_ch5_high", c5);
    push_exp("d12_rest_high", 0);
    push_exp("d12_ps_count", 1);
    push_exp("d12_ps_at_end", 1);
  endtask

  task automatic obs12();
    int rest;
    rest = 0;
    for (int i = 0; i < 12; i++) if (i != 5 && i != 11) rest += hi12[i];
    observe(hi12[11]);
    observe(hi12[5]);
    observe(rest);
    observe(ps12_n);
    observe(ps12_last);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_duty = '0;
    out_en = '0; pwm_en = '0; prescale = '0;
    cfg_we12 = 1'b0; cfg_ch12 = '0; cfg_duty12 = '0;
    out_en12 = '1; pwm_en12 = '1; prescale12 = '0;

    // Reset state.
    #3 rst_n = 1'b0;
    push_exp("rst_pwm_out", 0);
    push_exp("rst_period_start", 0);
    push_exp("rst_pwm_out12", 0);
    #20;
    observe(int'(pwm_out));
    observe(int'(period_start));
    observe(int'(pwm_out12));

    // First period_start 255 clk after release.
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("first_ps_delay", 255);
    run_to_ps(n_cyc, n_hi3);
    observe(n_cyc);

    // Channel configuration, committed at the next wrap.
    out_en = 16'h000F;
    pwm_en = 16'h000B;
    write16(0, 0);
    write16(1, 255);
    write16(2, 100);
    write16(3, 128);
    write16(4, 200);
    push_exp("cfg_period_rest", 250);
    run_to_ps(n_cyc, n_hi3);
    observe(n_cyc);

    // Mid-period write only affects the following period.
    exp16(0, 255, 255, 128);
    window(40, 3, 64, -1, 0, 0);
    obs16();
    exp16(0, 255, 255, 64);
    window(-1, 0, 0, -1, 0, 0);
    obs16();
    exp16(0, 255, 255, 64);
    window(100, 3, 128, -1, 0, 0);
    obs16();
    // Write coincident with the wrap is already in force next period.
    exp16(0, 255, 255, 128);
    window(254, 3, 64, -1, 0, 0);
    obs16();
    exp16(0, 255, 255, 64);
    window(-1, 0, 0, -1, 0, 0);
    obs16();

    // Prescale 3, duty 128: period 1020, high 512.
    prescale = 8'd3;
    write16(3, 128);
    push_exp("presc3_first_rest", 1019);
    run_to_ps(n_cyc, n_hi3);
    observe(n_cyc);
    push_exp("presc3_period", 1020);
    push_exp("presc3_ch3_high", 512);
    run_to_ps(n_cyc, n_hi3);
    observe(n_cyc);
    observe(n_hi3);

    // Drop prescale to 1 while presc_cnt is 2: tick next cycle, then every 2.
    step();
    step();
    prescale = 8'd1;
    push_exp("presc_drop_rest", 509);
    push_exp("presc_drop_ch3_high", 255);
    run_to_ps(n_cyc, n_hi3);
    observe(n_cyc);
    observe(n_hi3);
    push_exp("presc1_period", 510);
    push_exp("presc1_ch3_high", 256);
    run_to_ps(n_cyc, n_hi3);
    observe(n_cyc);
    observe(n_hi3);

    // Asynchronous reset mid-period while outputs are high.
    prescale = 8'd0;
    for (int k = 0; k < 20; k++) step();
    push_exp("pre_rst_ch2", 1);
    observe(int'(pwm_out[2]));
    @(negedge clk);
    #1 rst_n = 1'b0;
    push_exp("async_rst_pwm_out", 0);
    push_exp("async_rst_period_start", 0);
    #1;
    observe(int'(pwm_out));
    observe(int'(period_start));
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("rerst_ps_delay", 255);
    push_exp("rerst_d12_ps", 1);
    run_to_ps(n_cyc, n_hi3);
    observe(n_cyc);
    observe(int'(ps12));

    // 12-channel instance: out-of-range channel writes are dropped.
    exp12(0, 0);
    window(-1, 0, 0, 10, 11, 50);
    obs12();
    exp12(50, 0);
    window(-1, 0, 0, 10, 5, 255);
    obs12();
    exp12(50, 255);
    window(-1, 0, 0, 254, 13, 200);
    obs12();
    exp12(50, 255);
    window(-1, 0, 0, 30, 13, 200);
    obs12();
    exp12(50, 255);
    window(-1, 0, 0, -1, 0, 0);
    obs12();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
